// File: rtl/ens_vote_argmax.sv
// Ensemble vote: accumulates NUM_ENS signed class-score vectors, then scans for the
// highest summed score (lowest index on ties) and holds the result until it is taken.
module ens_vote_argmax #(
  parameter  int NUM_ENS     = 3,
  parameter  int NUM_CLASSES = 10,
  parameter  int SCORE_BITS  = 2,
  localparam int ACC_BITS    = SCORE_BITS + $clog2(NUM_ENS),
  localparam int CLS_BITS    = $clog2(NUM_CLASSES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CLASSES*SCORE_BITS-1:0]   in_scores,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CLS_BITS-1:0]                 out_class,
  output logic signed [ACC_BITS-1:0]          out_score
);

  localparam int CNT_W = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CLS_BITS-1:0]        idx_p1;
  logic signed [ACC_BITS-1:0] acc_p0 [NUM_CLASSES];
  logic signed [ACC_BITS-1:0] best_p1;
  logic [CLS_BITS-1:0]        best_idx_p1;

  logic                       accept, beat_last, scan_last, out_fire, gt;
  logic signed [ACC_BITS-1:0] cur;

  function automatic logic signed [ACC_BITS-1:0] sext(input logic [SCORE_BITS-1:0] s);
    logic signed [SCORE_BITS-1:0] ss;
    ss = s;
    return ACC_BITS'(ss);
  endfunction

  always_comb begin
    accept    = in_valid && in_ready;
    beat_last = (cnt_q == CNT_W'(NUM_ENS - 1));
    scan_last = (idx_p1 == CLS_BITS'(NUM_CLASSES - 1));
    out_fire  = out_valid && out_ready;
    cur       = acc_p0[idx_p1];
    gt        = (cur > best_p1);
    state_d   = state_q;
    case (state_q)
      ACCUM:   if (accept && beat_last) state_d = SCAN;
      SCAN:    if (scan_last)           state_d = OUT;
      OUT:     if (out_fire)            state_d = ACCUM;
      default:                          state_d = ACCUM;
    endcase
  end

  // p0: per-class accumulation; p1: sequential argmax; output registers hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      idx_p1    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) acc_p0[c] <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == ACCUM);
      case (state_q)
        ACCUM: begin
          if (accept) begin
            for (int c = 0; c < NUM_CLASSES; c++)
              acc_p0[c] <= acc_p0[c] + sext(in_scores[c*SCORE_BITS +: SCORE_BITS]);
            cnt_q  <= beat_last ? '0 : cnt_q + CNT_W'(1);
            idx_p1 <= '0;
          end
        end
        SCAN: begin
          idx_p1 <= scan_last ? '0 : idx_p1 + CLS_BITS'(1);
          if (scan_last) begin
            out_valid <= 1'b1;
            out_class <= gt ? idx_p1 : best_idx_p1;
            out_score <= gt ? cur : best_p1;
          end
        end
        OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) acc_p0[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // strict compare keeps the earliest index on ties
  always_ff @(posedge clk) begin
    if (state_q == SCAN && (idx_p1 == '0 || gt)) begin
      best_p1     <= cur;
      best_idx_p1 <= idx_p1;
    end
  end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Scoreboard bench for ens_vote_argmax: a reference sum/argmax model queues expected
// results as beats are accepted; a monitor compares them at each output handshake.
module tb_ens_vote_argmax;
  localparam int NE = 3;
  localparam int NC = 10;
  localparam int SB = 2;
  localparam int AB = SB + $clog2(NE);
  localparam int CB = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [NC*SB-1:0]     in_scores;
  logic                 out_valid;
  logic                 out_ready;
  logic [CB-1:0]        out_class;
  logic signed [AB-1:0] out_score;

  typedef struct {int cls; int score;} exp_t;
  exp_t sbq[$];
  int   sums[NC];
  int   beats = 0;
  int   n_vec = 0;
  int   n_err = 0;

  ens_vote_argmax #(.NUM_ENS(NE), .NUM_CLASSES(NC), .SCORE_BITS(SB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_scores(in_scores), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) sums[c] = 0;
    beats = 0;
  endtask

  task automatic model_accept(input logic [NC*SB-1:0] v);
    logic signed [SB-1:0] s;
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      s = v[c*SB +: SB];
      sums[c] += int'(s);
    end
    beats++;
    if (beats == NE) begin
      e.cls = 0;
      e.score = sums[0];
      for (int c = 1; c < NC; c++)
        if (sums[c] > e.score) begin
          e.score = sums[c];
          e.cls = c;
        end
      sbq.push_back(e);
      model_clear();
    end
  endtask

  task automatic send_beat(input logic [NC*SB-1:0] v);
    int t;
    logic took;
    in_valid  = 1'b1;
    in_scores = v;
    t = 0;
    took = 1'b0;
    while (!took && t < 100) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!took) chk("beat_timeout", 0, 1);
    else model_accept(v);
  endtask

  function automatic logic [NC*SB-1:0] one_hot(input int c, input logic [SB-1:0] s);
    logic [NC*SB-1:0] v;
    v = '0;
    v[c*SB +: SB] = s;
    return v;
  endfunction

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("out_class", int'(out_class), e.cls);
        chk("out_score", int'(out_score), e.score);
      end
    end
  end

  initial begin
    int lat, t;
    logic bad;
    logic [CB-1:0] hc;
    logic signed [AB-1:0] hs;
    logic [NC*SB-1:0] v;

    rst = 1'b1; in_valid = 1'b0; in_scores = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_score", int'(out_score), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    t = 0;
    while (!in_ready && t < 3) begin @(posedge clk); #1; t++; end
    chk("ready_after_rst", int'(in_ready), 1);

    // 1: class 7 wins, latency and in_ready gating
    out_ready = 1'b1;
    for (int b = 0; b < NE; b++) send_beat(one_hot(7, 2'b01));
    lat = 0; bad = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, NC);
    chk("out_class_t1", int'(out_class), 7);
    chk("out_score_t1", int'(out_score), 3);
    chk("busy_in_ready", int'(bad || in_ready), 0);
    @(posedge clk); #1;
    chk("valid_after_hs", int'(out_valid), 0);
    chk("ready_after_hs", int'(in_ready), 1);

    // 2: tie between classes 2 and 5
    send_beat(one_hot(2, 2'b01) | one_hot(5, 2'b01));
    send_beat(one_hot(2, 2'b01) | one_hot(5, 2'b01));
    send_beat('0);
    wait_drain();

    // 3: all scores at the negative limit
    for (int b = 0; b < NE; b++) send_beat({NC{2'b10}});
    wait_drain();

    // 4: output backpressure with in_valid held high
    out_ready = 1'b0;
    for (int b = 0; b < NE; b++) send_beat(one_hot(3, 2'b01));
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_valid", int'(out_valid), 1);
    hc = out_class; hs = out_score;
    chk("bp_class", int'(hc), 3);
    in_valid = 1'b1; in_scores = one_hot(0, 2'b01);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!out_valid || out_class != hc || out_score != hs || in_ready) bad = 1'b1;
    end
    chk("bp_stable", int'(bad), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    send_beat(one_hot(8, 2'b01));
    send_beat('0);
    send_beat('0);
    wait_drain();

    // 5: reset discards a partial accumulation
    send_beat(one_hot(4, 2'b01));
    send_beat(one_hot(4, 2'b01));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk("midrst_in_ready", int'(in_ready), 0);
    for (int b = 0; b < NE; b++) send_beat(one_hot(9, 2'b01));
    chk("t5_queued", sbq.size(), 1);
    if (sbq.size() == 1) begin
      chk("t5_cls_model", sbq[0].cls, 9);
      chk("t5_score_model", sbq[0].score, 3);
    end
    wait_drain();

    // 6: random gaps and scores
    for (int n = 0; n < 200; n++) begin
      for (int b = 0; b < NE; b++) begin
        v = NC*SB'($urandom);
        send_beat(v);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
